// File: rtl/rider_steer_ctrl.sv
// ---------------------------------------------------------------------------
// rider_steer_ctrl
//   Rider-detect / steering-enable controller for the balance platform.
//   Left/right load-cell samples are registered, summed and differenced.
//   Total weight is compared against a hysteresis band around MIN_WT.
//   A three-state FSM (IDLE, WAIT, STEER) decides when steering may be
//   enabled. Steering is enabled only after a settle timer has run while
//   the rider stays balanced. A debounced one-cycle rider_off pulse
//   reports that the rider has stepped off.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   lft_ld       in   LD_W   left load-cell sample, unsigned
//   rght_ld      in   LD_W   right load-cell sample, unsigned
//   en_steer     out  1      steering enabled (high exactly while in STEER)
//   rider_off    out  1      one-cycle pulse after any WAIT/STEER -> IDLE
//   steer_state  out  2      FSM state register: 0 IDLE, 1 WAIT, 2 STEER
//
// Handshake: there is no valid/ready interface. A new sample is accepted
//   on every rising edge of clk. Every decision uses the samples that were
//   registered on the previous edge.
// ---------------------------------------------------------------------------
module rider_steer_ctrl #(
  parameter int LD_W       = 12,
  parameter int MIN_WT     = 'h200,
  parameter int WT_HYST    = 'h040,
  parameter int BAL_SHFT   = 2,
  parameter int LOST_SHFT  = 5,
  parameter int TMR_W      = 26,
  parameter int FAST_SIM   = 0,
  parameter int FAST_TMR_W = 15,
  parameter int OFF_DBNC   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      steer_state
);

  // Number of timer LSBs that must be all ones for the timer to count as
  // "settled". A fast simulation build uses a shorter settle time.
  localparam int TW = (FAST_SIM != 0) ? FAST_TMR_W : TMR_W;

  // The debounce counter must be able to hold OFF_DBNC itself, because it
  // saturates at that value.
  localparam int OC_W = $clog2(OFF_DBNC + 1);

  localparam int LO_I      = MIN_WT - WT_HYST;
  localparam int HI_I      = MIN_WT + WT_HYST;
  localparam int OFF_MAX_I = OFF_DBNC;
  localparam int OFF_M1_I  = OFF_DBNC - 1;

  localparam logic [LD_W:0]   LO_TH   = LO_I[LD_W:0];
  localparam logic [LD_W:0]   HI_TH   = HI_I[LD_W:0];
  localparam logic [OC_W-1:0] OFF_MAX = OFF_MAX_I[OC_W-1:0];
  localparam logic [OC_W-1:0] OFF_M1  = OFF_M1_I[OC_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STEER = 2'd2
  } state_t;

  state_t          state;
  logic [LD_W-1:0] lft_q;
  logic [LD_W-1:0] rght_q;
  logic [TMR_W-1:0] tmr;
  logic [OC_W-1:0] off_cnt;

  logic [LD_W:0]   sum;
  logic [LD_W:0]   diff;
  logic [LD_W-1:0] abs_diff;
  logic [LD_W:0]   abs_diff_x;
  logic [LD_W:0]   bal_th;
  logic [LD_W:0]   lost_th;
  logic            sum_lt_min;
  logic            sum_gt_min;
  logic            balanced;
  logic            lost;
  logic            off_ok;
  logic            full;

  // One extra bit of width keeps the sum from overflowing.
  assign sum = {1'b0, lft_q} + {1'b0, rght_q};

  // The difference is taken at LD_W+1 bits, so the top bit is the sign.
  // The magnitude is at most 2^LD_W-1, so it fits exactly in LD_W bits.
  assign diff       = {1'b0, lft_q} - {1'b0, rght_q};
  assign abs_diff   = diff[LD_W] ? LD_W'(-diff) : LD_W'(diff);
  assign abs_diff_x = {1'b0, abs_diff};

  assign sum_lt_min = (sum < LO_TH);
  assign sum_gt_min = (sum > HI_TH);

  assign bal_th   = sum >> BAL_SHFT;
  // lost_th cannot underflow, because sum>>LOST_SHFT is never more than sum.
  assign lost_th  = sum - (sum >> LOST_SHFT);
  assign balanced = (abs_diff_x < bal_th);
  assign lost     = (abs_diff_x > lost_th);

  // off_cnt counts the earlier consecutive low samples. When it reaches
  // OFF_DBNC-1, the current low sample is the OFF_DBNC-th one.
  assign off_ok = sum_lt_min && ((off_cnt == OFF_M1) || (off_cnt == OFF_MAX));

  assign full = &tmr[TW-1:0];

  assign steer_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q     <= '0;
      rght_q    <= '0;
      state     <= S_IDLE;
      tmr       <= '0;
      off_cnt   <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b0;
    end else begin
      lft_q  <= lft_ld;
      rght_q <= rght_ld;

      if (sum_lt_min) begin
        if (off_cnt != OFF_MAX) begin
          off_cnt <= off_cnt + 1'b1;
        end
      end else begin
        off_cnt <= '0;
      end

      rider_off <= 1'b0;

      case (state)
        S_IDLE: begin
          en_steer <= 1'b0;
          if (sum_gt_min) begin
            state <= S_WAIT;
            tmr   <= '0;
          end
        end

        S_WAIT: begin
          if (off_ok) begin
            state     <= S_IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
          end else if (!balanced) begin
            // Being out of balance always restarts the settle time.
            // This includes the cycle in which the timer is already full.
            tmr <= '0;
          end else if (full) begin
            state    <= S_STEER;
            en_steer <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_STEER: begin
          if (off_ok) begin
            state     <= S_IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
          end else if (lost) begin
            state    <= S_WAIT;
            tmr      <= '0;
            en_steer <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          en_steer <= 1'b0;
        end
      endcase
    end
  end

endmodule
